// File: rtl/dwt4db_analysis.sv
`default_nettype none
// dwt4db_analysis: one-level Daubechies-4 analysis (Q8 taps), serial x in, registered (a, d) pair out.
// Define DWT4DB_SAT_EN to saturate a/d instead of wrapping.  Rev 1.0
module dwt4db_analysis #(
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic [DW-1:0] x,
  input  logic          x_valid,
  output logic [DW-1:0] a,
  output logic [DW-1:0] d,
  output logic          ad_valid
);

  localparam int AW = DW + 10;
  localparam logic signed [9:0] H [4] = '{10'sd124, 10'sd214, 10'sd57, -10'sd33};
  localparam logic signed [9:0] G [4] = '{-10'sd33, -10'sd57, 10'sd214, -10'sd124};

  logic                 phase;
  logic signed [DW-1:0] hist [3];
  logic signed [DW-1:0] win [4];
  logic                 win_valid;
  logic signed [AW-1:0] prod_a [4];
  logic signed [AW-1:0] prod_d [4];
  logic                 prod_valid;
  logic signed [AW-1:0] acc_a;
  logic signed [AW-1:0] acc_d;
  logic signed [DW+1:0] sh_a;
  logic signed [DW+1:0] sh_d;
  logic        [DW-1:0] a_next;
  logic        [DW-1:0] d_next;

  // History is a plain shift register: at an ODD acceptance it holds x[2k], x[2k-1], x[2k-2].
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase     <= 1'b0;
      win_valid <= 1'b0;
      for (int i = 0; i < 3; i++) hist[i] <= '0;
      for (int i = 0; i < 4; i++) win[i] <= '0;
    end else if (clr) begin
      phase     <= 1'b0;
      win_valid <= 1'b0;
      for (int i = 0; i < 3; i++) hist[i] <= '0;
      for (int i = 0; i < 4; i++) win[i] <= '0;
    end else begin
      win_valid <= x_valid && phase;
      if (x_valid) begin
        phase   <= ~phase;
        hist[0] <= $signed(x);
        hist[1] <= hist[0];
        hist[2] <= hist[1];
        if (phase) begin
          win[0] <= $signed(x);
          win[1] <= hist[0];
          win[2] <= hist[1];
          win[3] <= hist[2];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prod_valid <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        prod_a[i] <= '0;
        prod_d[i] <= '0;
      end
    end else if (clr) begin
      prod_valid <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        prod_a[i] <= '0;
        prod_d[i] <= '0;
      end
    end else begin
      prod_valid <= win_valid;
      if (win_valid) begin
        for (int i = 0; i < 4; i++) begin
          prod_a[i] <= win[i] * H[i];
          prod_d[i] <= win[i] * G[i];
        end
      end
    end
  end

  always_comb begin
    acc_a = prod_a[0] + prod_a[1] + prod_a[2] + prod_a[3];
    acc_d = prod_d[0] + prod_d[1] + prod_d[2] + prod_d[3];
  end

  // Dropping the low 8 bits of a signed value is a floor-rounded arithmetic shift.
  assign sh_a = acc_a[AW-1:8];
  assign sh_d = acc_d[AW-1:8];

  logic unused_low_bits;
  assign unused_low_bits = ^{acc_a[7:0], acc_d[7:0]};

`ifdef DWT4DB_SAT_EN
  localparam logic signed [DW+1:0] SAT_HI = {3'b000, {(DW-1){1'b1}}};
  localparam logic signed [DW+1:0] SAT_LO = {3'b111, {(DW-1){1'b0}}};

  function automatic logic [DW-1:0] sat(input logic signed [DW+1:0] v);
    if (v > SAT_HI)      sat = SAT_HI[DW-1:0];
    else if (v < SAT_LO) sat = SAT_LO[DW-1:0];
    else                 sat = v[DW-1:0];
  endfunction

  assign a_next = sat(sh_a);
  assign d_next = sat(sh_d);
`else
  logic unused_top_bits;
  assign unused_top_bits = ^{sh_a[DW+1:DW], sh_d[DW+1:DW]};
  assign a_next = sh_a[DW-1:0];
  assign d_next = sh_d[DW-1:0];
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a        <= '0;
      d        <= '0;
      ad_valid <= 1'b0;
    end else if (clr) begin
      a        <= '0;
      d        <= '0;
      ad_valid <= 1'b0;
    end else begin
      ad_valid <= prod_valid;
      if (prod_valid) begin
        a <= a_next;
        d <= d_next;
      end
    end
  end

endmodule
`default_nettype wire
